// File: rtl/phy_addr_translation_unit_pkg.sv
// Shared types for the logical->physical address translator.
// Holds the memory-map result enum, the region table entry layout, the
// power-on region table and the per-entry match function.
package phy_addr_translation_unit_pkg;

    localparam int unsigned LOG_ADDR_WIDTH   = 32;
    localparam int unsigned PHY_ADDR_WIDTH   = 30;
    localparam int unsigned RAW_ADDR_WIDTH   = PHY_ADDR_WIDTH - 2;
    localparam int unsigned REGION_NUM       = 8;
    localparam int unsigned REGION_IDX_WIDTH = $clog2(REGION_NUM);
    localparam int unsigned MISS_CNT_WIDTH   = 16;

    typedef enum logic [1:0] {
        MMT_MEMORY  = 2'd0,
        MMT_IO      = 2'd1,
        MMT_ILLEGAL = 2'd2
    } MemoryMapType;

    typedef struct packed {
        logic                      valid;
        logic                      locked;
        logic                      isIO;
        logic                      isUncachable;
        logic [LOG_ADDR_WIDTH-1:0] base;
        logic [LOG_ADDR_WIDTH-1:0] mask;
        logic [RAW_ADDR_WIDTH-1:0] phyBase;
    } RegionEntry;

    // Standard memory map restored on every reset.
    localparam RegionEntry RESET_E0 = '{valid: 1'b1, locked: 1'b1, isIO: 1'b1, isUncachable: 1'b1,
                                        base: 32'h4000_2000, mask: 32'h0000_0000, phyBase: 28'h000_2000};
    localparam RegionEntry RESET_E1 = '{valid: 1'b1, locked: 1'b1, isIO: 1'b1, isUncachable: 1'b1,
                                        base: 32'h4000_0000, mask: 32'h0000_000F, phyBase: 28'h000_0000};
    localparam RegionEntry RESET_E2 = '{valid: 1'b1, locked: 1'b0, isIO: 1'b0, isUncachable: 1'b1,
                                        base: 32'h9000_0000, mask: 32'h0FFF_FFFF, phyBase: 28'h001_0000};
    localparam RegionEntry RESET_E3 = '{valid: 1'b1, locked: 1'b0, isIO: 1'b0, isUncachable: 1'b0,
                                        base: 32'h0000_0000, mask: 32'h0000_FFFF, phyBase: 28'h000_0000};
    localparam RegionEntry RESET_E4 = '{valid: 1'b1, locked: 1'b0, isIO: 1'b0, isUncachable: 1'b0,
                                        base: 32'h8000_0000, mask: 32'h0FFF_FFFF, phyBase: 28'h001_0000};
    localparam RegionEntry RESET_OFF = '0;

    localparam RegionEntry [REGION_NUM-1:0] RESET_TABLE =
        {{(REGION_NUM-5){RESET_OFF}}, RESET_E4, RESET_E3, RESET_E2, RESET_E1, RESET_E0};

    // An address hits an entry when the bits outside the mask equal the base.
    function automatic logic GetRegionMatch(input logic [LOG_ADDR_WIDTH-1:0] addr,
                                            input RegionEntry entry);
        return entry.valid && ((addr & ~entry.mask) == entry.base);
    endfunction

endpackage

// File: rtl/phy_addr_translation_unit_region_table.sv
// Programmable region table.
// Ports: clk/rst; lookup_addr -> match_vec (one bit per entry, combinational);
// read_index -> read_* (attributes of the selected entry, combinational);
// cfg_we/cfg_index/cfg_entry write port; cfg_error pulses one cycle after a
// write aimed at a locked entry.
module phy_addr_translation_unit_region_table
    import phy_addr_translation_unit_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic [LOG_ADDR_WIDTH-1:0]   lookup_addr,
    output logic [REGION_NUM-1:0]       match_vec,
    input  logic [REGION_IDX_WIDTH-1:0] read_index,
    output logic                        read_io,
    output logic                        read_uc,
    output logic [LOG_ADDR_WIDTH-1:0]   read_mask,
    output logic [RAW_ADDR_WIDTH-1:0]   read_phy_base,
    input  logic                        cfg_we,
    input  logic [REGION_IDX_WIDTH-1:0] cfg_index,
    input  RegionEntry                  cfg_entry,
    output logic                        cfg_error
);

    RegionEntry table_q [REGION_NUM];

    // Entry storage. Only unlocked entries accept writes, so a set lock bit
    // can only be cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < REGION_NUM; i++) begin
                table_q[i] <= RESET_TABLE[i];
            end
            cfg_error <= 1'b0;
        end else begin
            cfg_error <= 1'b0;
            if (cfg_we) begin
                if (table_q[cfg_index].locked) begin
                    cfg_error <= 1'b1;
                end else begin
                    table_q[cfg_index] <= cfg_entry;
                end
            end
        end
    end

    // Parallel match of the lookup address against every entry.
    always_comb begin
        match_vec = '0;
        for (int unsigned i = 0; i < REGION_NUM; i++) begin
            match_vec[i] = GetRegionMatch(lookup_addr, table_q[i]);
        end
    end

    assign read_io       = table_q[read_index].isIO;
    assign read_uc       = table_q[read_index].isUncachable;
    assign read_mask     = table_q[read_index].mask;
    assign read_phy_base = table_q[read_index].phyBase;

endmodule

// File: rtl/phy_addr_translation_unit.sv
// Two-stage pipelined logical->physical address translator.
// Ports: reqValid/reqReady/reqAddr request handshake; rspValid/rspReady with
// rspPhyAddr {isUncachable,isIO,raw} and rspType (MemoryMapType) response;
// cfgWe/cfgIndex/cfgEntry table write port with cfgError drop pulse;
// missCount saturating MMT_ILLEGAL counter, cleared by missCountClear.
module phy_addr_translation_unit
    import phy_addr_translation_unit_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        reqValid,
    output logic                        reqReady,
    input  logic [LOG_ADDR_WIDTH-1:0]   reqAddr,
    output logic                        rspValid,
    input  logic                        rspReady,
    output logic [PHY_ADDR_WIDTH-1:0]   rspPhyAddr,
    output logic [1:0]                  rspType,
    input  logic                        cfgWe,
    input  logic [REGION_IDX_WIDTH-1:0] cfgIndex,
    input  RegionEntry                  cfgEntry,
    output logic                        cfgError,
    output logic [MISS_CNT_WIDTH-1:0]   missCount,
    input  logic                        missCountClear
);

    logic                        advance;
    logic [REGION_NUM-1:0]       match_c;
    logic [REGION_IDX_WIDTH-1:0] hit_idx_c;
    logic                        sel_io;
    logic                        sel_uc;
    logic [LOG_ADDR_WIDTH-1:0]   sel_mask;
    logic [RAW_ADDR_WIDTH-1:0]   sel_phy_base;

    logic                        s1_valid;
    logic [LOG_ADDR_WIDTH-1:0]   s1_addr;
    logic [REGION_NUM-1:0]       s1_match;
    logic                        s1_io;
    logic                        s1_uc;
    logic [LOG_ADDR_WIDTH-1:0]   s1_mask;
    logic [RAW_ADDR_WIDTH-1:0]   s1_phy_base;

    logic                        s1_hit;
    logic [LOG_ADDR_WIDTH-1:0]   offset_c;
    logic [RAW_ADDR_WIDTH-1:0]   raw_c;
    logic [PHY_ADDR_WIDTH-1:0]   phy_c;
    MemoryMapType                type_c;
    logic                        miss_event;

    // Both stages move together; the output register is the second stage.
    assign advance  = !rspValid || rspReady;
    assign reqReady = advance;

    phy_addr_translation_unit_region_table u_region_table (
        .clk           (clk),
        .rst           (rst),
        .lookup_addr   (reqAddr),
        .match_vec     (match_c),
        .read_index    (hit_idx_c),
        .read_io       (sel_io),
        .read_uc       (sel_uc),
        .read_mask     (sel_mask),
        .read_phy_base (sel_phy_base),
        .cfg_we        (cfgWe),
        .cfg_index     (cfgIndex),
        .cfg_entry     (cfgEntry),
        .cfg_error     (cfgError)
    );

    // Lowest matching index wins: scan downward so the last hit assigned is the lowest.
    always_comb begin
        hit_idx_c = '0;
        for (int i = REGION_NUM - 1; i >= 0; i--) begin
            if (match_c[i]) begin
                hit_idx_c = REGION_IDX_WIDTH'(i);
            end
        end
    end

    // Stage 1. The winning entry's attributes are snapshotted here so a later
    // table write cannot alter a request already in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s1_addr     <= '0;
            s1_match    <= '0;
            s1_io       <= 1'b0;
            s1_uc       <= 1'b0;
            s1_mask     <= '0;
            s1_phy_base <= '0;
        end else if (advance) begin
            s1_valid    <= reqValid;
            s1_addr     <= reqAddr;
            s1_match    <= match_c;
            s1_io       <= sel_io;
            s1_uc       <= sel_uc;
            s1_mask     <= sel_mask;
            s1_phy_base <= sel_phy_base;
        end
    end

    // Result encoding from the stage-1 snapshot.
    always_comb begin
        s1_hit   = |s1_match;
        offset_c = s1_addr & s1_mask;
        raw_c    = s1_phy_base + offset_c[RAW_ADDR_WIDTH-1:0];
        phy_c    = '0;
        type_c   = MMT_ILLEGAL;
        if (s1_hit) begin
            phy_c  = {s1_uc, s1_io, raw_c};
            type_c = s1_io ? MMT_IO : MMT_MEMORY;
        end
    end

    // Stage 2 / response register; payload holds while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            rspValid   <= 1'b0;
            rspPhyAddr <= '0;
            rspType    <= '0;
        end else if (advance) begin
            rspValid <= s1_valid;
            if (s1_valid) begin
                rspPhyAddr <= phy_c;
                rspType    <= type_c;
            end
        end
    end

    // A miss is counted once, when its response is loaded into stage 2.
    assign miss_event = advance && s1_valid && !s1_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            missCount <= '0;
        end else if (missCountClear) begin
            missCount <= '0;
        end else if (miss_event && (missCount != '1)) begin
            missCount <= missCount + MISS_CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_phy_addr_translation_unit.sv
// Directed self-checking bench for phy_addr_translation_unit.
// Inputs are driven and outputs sampled right after the falling edge.
module tb_phy_addr_translation_unit;
    import phy_addr_translation_unit_pkg::*;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        reqValid;
    logic                        reqReady;
    logic [LOG_ADDR_WIDTH-1:0]   reqAddr;
    logic                        rspValid;
    logic                        rspReady;
    logic [PHY_ADDR_WIDTH-1:0]   rspPhyAddr;
    logic [1:0]                  rspType;
    logic                        cfgWe;
    logic [REGION_IDX_WIDTH-1:0] cfgIndex;
    RegionEntry                  cfgEntry;
    logic                        cfgError;
    logic [MISS_CNT_WIDTH-1:0]   missCount;
    logic                        missCountClear;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    phy_addr_translation_unit dut (
        .clk            (clk),
        .rst            (rst),
        .reqValid       (reqValid),
        .reqReady       (reqReady),
        .reqAddr        (reqAddr),
        .rspValid       (rspValid),
        .rspReady       (rspReady),
        .rspPhyAddr     (rspPhyAddr),
        .rspType        (rspType),
        .cfgWe          (cfgWe),
        .cfgIndex       (cfgIndex),
        .cfgEntry       (cfgEntry),
        .cfgError       (cfgError),
        .missCount      (missCount),
        .missCountClear (missCountClear)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic RegionEntry mk_entry(input logic lk, input logic io, input logic uc,
                                            input logic [31:0] base, input logic [31:0] mask,
                                            input logic [27:0] phy);
        RegionEntry e;
        e = '{valid: 1'b1, locked: lk, isIO: io, isUncachable: uc,
              base: base, mask: mask, phyBase: phy};
        return e;
    endfunction

    // Drive a single request with the output always ready; return with its response visible.
    task automatic send_one(input logic [31:0] addr);
        reqValid = 1'b1;
        reqAddr  = addr;
        step();
        reqValid = 1'b0;
        step();
    endtask

    task automatic check_rsp(input string tag, input logic [29:0] phy, input logic [1:0] typ);
        check_eq({tag, "_valid"}, 64'(rspValid), 64'(1));
        check_eq({tag, "_phy"}, 64'(rspPhyAddr), 64'(phy));
        check_eq({tag, "_type"}, 64'(rspType), 64'(typ));
    endtask

    task automatic write_cfg(input logic [2:0] idx, input RegionEntry e);
        cfgWe    = 1'b1;
        cfgIndex = idx;
        cfgEntry = e;
        step();
        cfgWe    = 1'b0;
    endtask

    localparam int NV = 10;
    logic [31:0] v_addr [NV];
    logic [29:0] v_phy  [NV];
    logic [1:0]  v_type [NV];

    initial begin
        v_addr[0] = 32'h4000_2000; v_phy[0] = 30'h3000_2000; v_type[0] = MMT_IO;
        v_addr[1] = 32'h8000_0010; v_phy[1] = 30'h0001_0010; v_type[1] = MMT_MEMORY;
        v_addr[2] = 32'h9000_0020; v_phy[2] = 30'h2001_0020; v_type[2] = MMT_MEMORY;
        v_addr[3] = 32'h0000_1004; v_phy[3] = 30'h0000_1004; v_type[3] = MMT_MEMORY;
        v_addr[4] = 32'h4000_0007; v_phy[4] = 30'h3000_0007; v_type[4] = MMT_IO;
        v_addr[5] = 32'h4000_2001; v_phy[5] = 30'h0;         v_type[5] = MMT_ILLEGAL;
        v_addr[6] = 32'h0000_FFFF; v_phy[6] = 30'h0000_FFFF; v_type[6] = MMT_MEMORY;
        v_addr[7] = 32'h0001_0000; v_phy[7] = 30'h0;         v_type[7] = MMT_ILLEGAL;
        v_addr[8] = 32'h8FFF_FFFF; v_phy[8] = 30'h0000_FFFF; v_type[8] = MMT_MEMORY;
        v_addr[9] = 32'hA000_0000; v_phy[9] = 30'h0;         v_type[9] = MMT_ILLEGAL;

        rst = 1'b1; reqValid = 1'b0; reqAddr = '0; rspReady = 1'b1;
        cfgWe = 1'b0; cfgIndex = '0; cfgEntry = '0; missCountClear = 1'b0;
        step(); step();
        check_eq("rst_rspValid", 64'(rspValid), 64'(0));
        check_eq("rst_cfgError", 64'(cfgError), 64'(0));
        check_eq("rst_missCount", 64'(missCount), 64'(0));
        check_eq("rst_rspPhyAddr", 64'(rspPhyAddr), 64'(0));
        check_eq("rst_rspType", 64'(rspType), 64'(0));
        rst = 1'b0;
        step();

        // First request: nothing after one edge, response after the second.
        reqValid = 1'b1; reqAddr = 32'h4000_2000;
        check_eq("first_reqReady", 64'(reqReady), 64'(1));
        step();
        reqValid = 1'b0;
        check_eq("first_latency1", 64'(rspValid), 64'(0));
        step();
        check_rsp("first", 30'h3000_2000, MMT_IO);
        step();
        check_eq("first_drained", 64'(rspValid), 64'(0));

        // Back-to-back stream, one response per cycle.
        for (int i = 0; i < NV + 2; i++) begin
            if (i >= 2) check_rsp($sformatf("vec%0d", i - 2), v_phy[i-2], v_type[i-2]);
            reqValid = (i < NV);
            if (i < NV) reqAddr = v_addr[i];
            step();
        end
        check_eq("stream_missCount", 64'(missCount), 64'(3));

        // Single miss after clear, then clear held across a miss.
        missCountClear = 1'b1; step(); missCountClear = 1'b0;
        check_eq("clear_missCount", 64'(missCount), 64'(0));
        send_one(32'hA000_0000);
        check_rsp("miss", 30'h0, MMT_ILLEGAL);
        check_eq("miss_count1", 64'(missCount), 64'(1));
        step();
        missCountClear = 1'b1;
        send_one(32'hA000_0000);
        check_eq("clear_prio_count", 64'(missCount), 64'(0));
        missCountClear = 1'b0;
        step();
        check_eq("clear_prio_after", 64'(missCount), 64'(0));

        // Backpressure: three requests, consumer stalled for three cycles.
        rspReady = 1'b0; reqValid = 1'b1; reqAddr = 32'h8000_0010;
        check_eq("stall_rdy0", 64'(reqReady), 64'(1));
        step();
        reqAddr = 32'h9000_0020;
        check_eq("stall_rdy1", 64'(reqReady), 64'(1));
        step();
        reqAddr = 32'h0000_1004;
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("stall_rdy_low%0d", i), 64'(reqReady), 64'(0));
            check_rsp($sformatf("stall_hold%0d", i), 30'h0001_0010, MMT_MEMORY);
            if (i < 2) step();
        end
        rspReady = 1'b1;
        step();
        reqValid = 1'b0;
        check_rsp("stall_r1", 30'h2001_0020, MMT_MEMORY);
        step();
        check_rsp("stall_r2", 30'h0000_1004, MMT_MEMORY);
        step();
        check_eq("stall_no_dup", 64'(rspValid), 64'(0));

        // Write e5 with a same-cycle request (old table), then a new request.
        cfgWe = 1'b1; cfgIndex = 3'd5;
        cfgEntry = mk_entry(1'b0, 1'b0, 1'b0, 32'hC000_0000, 32'h0000_0FFF, 28'h002_0000);
        reqValid = 1'b1; reqAddr = 32'hC000_0004;
        step();
        cfgWe = 1'b0;
        check_eq("cfg_e5_noerr", 64'(cfgError), 64'(0));
        step();
        reqValid = 1'b0;
        check_rsp("cfg_old_table", 30'h0, MMT_ILLEGAL);
        step();
        check_rsp("cfg_new_table", 30'h0002_0004, MMT_MEMORY);
        step();

        // Write to locked e0 is dropped and flagged for one cycle.
        write_cfg(3'd0, mk_entry(1'b0, 1'b0, 1'b0, 32'h5000_0000, 32'h0, 28'h123));
        check_eq("cfg_e0_err", 64'(cfgError), 64'(1));
        step();
        check_eq("cfg_e0_pulse", 64'(cfgError), 64'(0));
        send_one(32'h4000_2000);
        check_rsp("cfg_e0_kept", 30'h3000_2000, MMT_IO);
        step();

        // Lock set by a write sticks; later write to e6 is dropped.
        write_cfg(3'd6, mk_entry(1'b1, 1'b1, 1'b0, 32'hD000_0000, 32'h0, 28'h055));
        check_eq("cfg_e6_lock_noerr", 64'(cfgError), 64'(0));
        write_cfg(3'd6, mk_entry(1'b0, 1'b0, 1'b0, 32'hD000_0000, 32'h0, 28'h0AA));
        check_eq("cfg_e6_err", 64'(cfgError), 64'(1));
        send_one(32'hD000_0000);
        check_rsp("cfg_e6_kept", 30'h1000_0055, MMT_IO);
        step();

        // Overlapping e7 must lose to lower-index e4.
        write_cfg(3'd7, mk_entry(1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'h0FFF_FFFF, 28'h0F0_0000));
        send_one(32'h8000_0010);
        check_rsp("prio_low_wins", 30'h0001_0010, MMT_MEMORY);
        step();

        // Saturation of the miss counter.
        missCountClear = 1'b1; step(); missCountClear = 1'b0;
        reqValid = 1'b1; reqAddr = 32'hA000_0000;
        repeat (65536) step();
        reqValid = 1'b0;
        repeat (3) step();
        check_eq("sat_count", 64'(missCount), 64'hFFFF);
        send_one(32'hA000_0000);
        step();
        check_eq("sat_hold", 64'(missCount), 64'hFFFF);

        // Reset mid-stream flushes the pipe and restores the table.
        reqValid = 1'b1; reqAddr = 32'h8000_0010;
        step(); step();
        check_eq("midrst_pre", 64'(rspValid), 64'(1));
        rst = 1'b1;
        step();
        check_eq("midrst_rspValid", 64'(rspValid), 64'(0));
        rst = 1'b0; reqValid = 1'b0;
        step();
        check_eq("midrst_flushed", 64'(rspValid), 64'(0));
        check_eq("midrst_count", 64'(missCount), 64'(0));
        send_one(32'hC000_0004);
        check_rsp("midrst_e5_gone", 30'h0, MMT_ILLEGAL);
        step();
        write_cfg(3'd6, mk_entry(1'b0, 1'b0, 1'b0, 32'hE000_0000, 32'h0, 28'h077));
        check_eq("midrst_e6_unlocked", 64'(cfgError), 64'(0));
        send_one(32'hE000_0000);
        check_rsp("midrst_e6_write", 30'h0000_0077, MMT_MEMORY);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
